// File: rtl/zint_mc.sv
// Multi-channel Z80 /INT generator with fixed priority (channel 0 highest) and per-channel IM2 vectors.
// Optional build macro ZINT_REARM_EN keeps a timed-out request pending so it is served again after the gap.
module zint_mc #(
    parameter int         NCH       = 4,
    parameter int         CTR_W     = 8,
    parameter int         PULSE_LEN = 128,
    parameter int         GAP_LEN   = 4,
    parameter logic [7:0] VEC_BASE  = 8'hF0
) (
    input  logic           fclk,
    input  logic           rst,
    input  logic           zpos,
    input  logic           zneg,
    input  logic [NCH-1:0] int_req,
    input  logic [NCH-1:0] int_en,
    input  logic           iorq_n,
    input  logic           m1_n,
    output logic           int_n,
    output logic [7:0]     int_vec,
    output logic           ack_stb,
    output logic [2:0]     ack_ch,
    output logic           miss_stb
);

    typedef enum logic [1:0] {IDLE, ASSERT, ACKWAIT, GAP} state_t;

    state_t           state_q;
    logic [CTR_W-1:0] cnt_q;
    logic [2:0]       cur_q;
    logic [NCH-1:0]   pending_q;
    logic [NCH-1:0]   pending_d;
    logic [NCH-1:0]   clr_d;
    logic [NCH-1:0]   ready;
    logic [2:0]       sel_d;
    logic             int_n_q;
    logic [7:0]       int_vec_q;
    logic             ack_stb_q;
    logic [2:0]       ack_ch_q;
    logic             miss_stb_q;
    logic             ack;
    logic             timeout;
    logic             unused_zpos;

    assign unused_zpos = zpos;

    assign ack     = !iorq_n && !m1_n && zneg;
    assign timeout = (cnt_q == CTR_W'(PULSE_LEN - 1));
    assign ready   = pending_q & int_en;

    // Requests are latched even while masked, so enabling a channel later still serves it.
    always_comb begin
        clr_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (state_q == ASSERT && cur_q == 3'(i)) begin
                if (ack) begin
                    clr_d[i] = 1'b1;
                end
`ifdef ZINT_REARM_EN
`else
                else if (timeout) begin
                    clr_d[i] = 1'b1;
                end
`endif
            end
        end
        pending_d = (pending_q & ~clr_d) | int_req;
    end

    always_comb begin
        sel_d = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_d = 3'(i);
            end
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            int_n_q    <= 1'b1;
            int_vec_q  <= VEC_BASE;
            ack_stb_q  <= 1'b0;
            ack_ch_q   <= '0;
            miss_stb_q <= 1'b0;
        end else begin
            ack_stb_q  <= 1'b0;
            miss_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|ready) begin
                        cur_q     <= sel_d;
                        cnt_q     <= '0;
                        int_n_q   <= 1'b0;
                        int_vec_q <= {VEC_BASE[7:4], sel_d, 1'b0};
                        state_q   <= ASSERT;
                    end
                end
                ASSERT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Acknowledge beats a same-cycle timeout.
                    if (ack) begin
                        int_n_q   <= 1'b1;
                        ack_stb_q <= 1'b1;
                        ack_ch_q  <= cur_q;
                        state_q   <= ACKWAIT;
                    end else if (timeout) begin
                        int_n_q    <= 1'b1;
                        miss_stb_q <= 1'b1;
                        ack_ch_q   <= cur_q;
                        cnt_q      <= '0;
                        state_q    <= GAP;
                    end
                end
                ACKWAIT: begin
                    if (iorq_n) begin
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (cnt_q == CTR_W'(GAP_LEN - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign int_n    = int_n_q;
    assign int_vec  = int_vec_q;
    assign ack_stb  = ack_stb_q;
    assign ack_ch   = ack_ch_q;
    assign miss_stb = miss_stb_q;

endmodule

// File: tb/tb_zint_mc.sv
// Directed, table-driven bench for zint_mc; expectations follow ZINT_REARM_EN when defined.
module tb_zint_mc;

    localparam int NCH = 4;

    logic           fclk = 1'b0;
    logic           rst;
    logic           zpos;
    logic           zneg;
    logic [NCH-1:0] int_req;
    logic [NCH-1:0] int_en;
    logic           iorq_n;
    logic           m1_n;
    logic           int_n;
    logic [7:0]     int_vec;
    logic           ack_stb;
    logic [2:0]     ack_ch;
    logic           miss_stb;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] en;
        logic [7:0] vec;
        logic [2:0] ch;
    } vector_t;

    vector_t vectors [5];

    zint_mc #(
        .NCH(NCH), .CTR_W(8), .PULSE_LEN(128), .GAP_LEN(4), .VEC_BASE(8'hF0)
    ) dut (
        .fclk(fclk), .rst(rst), .zpos(zpos), .zneg(zneg),
        .int_req(int_req), .int_en(int_en), .iorq_n(iorq_n), .m1_n(m1_n),
        .int_n(int_n), .int_vec(int_vec), .ack_stb(ack_stb), .ack_ch(ack_ch),
        .miss_stb(miss_stb)
    );

    always #5 fclk = ~fclk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One-cycle request pulse; the edge at the end of this task latches it into pending.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] en);
        int_en  = en;
        int_req = req;
        tick(1);
        int_req = '0;
    endtask

    task automatic ackCycle(input logic [3:0] req);
        iorq_n  = 1'b0;
        m1_n    = 1'b0;
        zneg    = 1'b1;
        int_req = req;
        tick(1);
        zneg    = 1'b0;
        iorq_n  = 1'b1;
        m1_n    = 1'b1;
        int_req = '0;
    endtask

    initial begin
        vectors[0] = '{4'b0001, 4'b1111, 8'hF0, 3'd0};
        vectors[1] = '{4'b0010, 4'b1111, 8'hF2, 3'd1};
        vectors[2] = '{4'b0100, 4'b0110, 8'hF4, 3'd2};
        vectors[3] = '{4'b1000, 4'b1000, 8'hF6, 3'd3};
        vectors[4] = '{4'b0001, 4'b0001, 8'hF0, 3'd0};

        rst = 1'b1; zpos = 1'b0; zneg = 1'b0; iorq_n = 1'b1; m1_n = 1'b1;
        int_req = '0; int_en = '0;
        #1;
        checkOutput("reset int_n", 32'(int_n), 32'h1);
        checkOutput("reset int_vec", 32'(int_vec), 32'hF0);
        checkOutput("reset ack_stb", 32'(ack_stb), 32'h0);
        checkOutput("reset ack_ch", 32'(ack_ch), 32'h0);
        checkOutput("reset miss_stb", 32'(miss_stb), 32'h0);
        checkOutput("reset pending", 32'(dut.pending_q), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Single-channel service: 2-cycle latency, vector, ack 10 cycles later, drain gap.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vectors[v].req, vectors[v].en);
            tick(1);
            checkOutput($sformatf("vec%0d int_n low", v), 32'(int_n), 32'h0);
            checkOutput($sformatf("vec%0d int_vec", v), 32'(int_vec), 32'(vectors[v].vec));
            tick(9);
            ackCycle(4'b0000);
            checkOutput($sformatf("vec%0d ack_stb", v), 32'(ack_stb), 32'h1);
            checkOutput($sformatf("vec%0d ack_ch", v), 32'(ack_ch), 32'(vectors[v].ch));
            checkOutput($sformatf("vec%0d int_n released", v), 32'(int_n), 32'h1);
            checkOutput($sformatf("vec%0d pending cleared", v), 32'(dut.pending_q), 32'h0);
            tick(6);
        end

        // Priority: ch1 and ch3 together; ch1 first, ch3 after ACKWAIT and gap.
        applyStimulus(4'b1010, 4'b1111);
        tick(1);
        checkOutput("prio first vec", 32'(int_vec), 32'hF2);
        tick(3);
        ackCycle(4'b0000);
        checkOutput("prio first ack_ch", 32'(ack_ch), 32'h1);
        checkOutput("prio pending left", 32'(dut.pending_q), 32'h8);
        tick(5);
        checkOutput("prio gap int_n high", 32'(int_n), 32'h1);
        tick(1);
        checkOutput("prio second int_n low", 32'(int_n), 32'h0);
        checkOutput("prio second vec", 32'(int_vec), 32'hF6);
        ackCycle(4'b0000);
        checkOutput("prio second ack_ch", 32'(ack_ch), 32'h3);
        tick(6);

        // Timeout on ch2 after 128 cycles low.
        applyStimulus(4'b0100, 4'b1111);
        tick(1);
        tick(127);
        checkOutput("timeout still low", 32'(int_n), 32'h0);
        tick(1);
        checkOutput("timeout int_n high", 32'(int_n), 32'h1);
        checkOutput("timeout miss_stb", 32'(miss_stb), 32'h1);
        checkOutput("timeout ack_stb", 32'(ack_stb), 32'h0);
        checkOutput("timeout ack_ch", 32'(ack_ch), 32'h2);
        tick(1);
        checkOutput("timeout miss_stb pulse", 32'(miss_stb), 32'h0);
`ifdef ZINT_REARM_EN
        checkOutput("rearm pending kept", 32'(dut.pending_q), 32'h4);
        tick(3);
        checkOutput("rearm gap int_n high", 32'(int_n), 32'h1);
        tick(1);
        checkOutput("rearm int_n low", 32'(int_n), 32'h0);
        checkOutput("rearm vec", 32'(int_vec), 32'hF4);
        ackCycle(4'b0000);
        checkOutput("rearm ack_ch", 32'(ack_ch), 32'h2);
        tick(6);
`else
        checkOutput("drop pending cleared", 32'(dut.pending_q), 32'h0);
        tick(6);
        checkOutput("drop int_n stays high", 32'(int_n), 32'h1);
`endif

        // Ack coincides with the timeout cycle, and ch0 re-requests on the same cycle.
        applyStimulus(4'b0001, 4'b1111);
        tick(1);
        tick(127);
        ackCycle(4'b0001);
        checkOutput("simul ack_stb", 32'(ack_stb), 32'h1);
        checkOutput("simul miss_stb", 32'(miss_stb), 32'h0);
        checkOutput("simul pending set wins", 32'(dut.pending_q), 32'h1);
        tick(5);
        checkOutput("simul gap int_n high", 32'(int_n), 32'h1);
        tick(1);
        checkOutput("simul reserve int_n low", 32'(int_n), 32'h0);
        checkOutput("simul reserve vec", 32'(int_vec), 32'hF0);
        ackCycle(4'b0000);
        tick(6);

        // Masked request stays pending and is served once enabled.
        applyStimulus(4'b0100, 4'b1011);
        tick(2);
        checkOutput("mask int_n high", 32'(int_n), 32'h1);
        checkOutput("mask pending kept", 32'(dut.pending_q), 32'h4);
        int_en = 4'b1111;
        tick(2);
        checkOutput("unmask int_n low", 32'(int_n), 32'h0);
        checkOutput("unmask vec", 32'(int_vec), 32'hF4);
        ackCycle(4'b0000);
        tick(6);

        // Asynchronous reset during a pulse.
        applyStimulus(4'b0010, 4'b1111);
        tick(1);
        checkOutput("midrst int_n low", 32'(int_n), 32'h0);
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst async release", 32'(int_n), 32'h1);
        checkOutput("midrst pending", 32'(dut.pending_q), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(1);
        checkOutput("midrst no ack_stb", 32'(ack_stb), 32'h0);
        checkOutput("midrst no miss_stb", 32'(miss_stb), 32'h0);
        tick(130);
        checkOutput("midrst idle int_n", 32'(int_n), 32'h1);
        checkOutput("midrst late miss_stb", 32'(miss_stb), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
